// File: rtl/irq_sequencer_pkg.sv
// Shared constants, FSM encoding and priority helper for the interrupt sequencer.
package irq_sequencer_pkg;
  localparam int          NSRC       = 3;
  localparam int          AW         = 32;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0200;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0040;

  typedef enum logic [1:0] {IDLE, WAIT, TAKE, RET} state_e;

  // Index of the highest set bit, -1 when none is set.
  function automatic int prio_enc(input logic [31:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/irq_epc_stack.sv
// Resume-PC LIFO, one entry per nesting level; top reads 0 when empty.
module irq_epc_stack
  import irq_sequencer_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          in_RST,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] top_o
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [SPW-1:0] sp_q;
  logic [DW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] top_idx;

  assign top_idx = sp_q - SPW'(1);
  assign top_o   = (sp_q == '0) ? '0 : mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (!in_RST) begin
      sp_q <= '0;
    end else if (push_i && sp_q != SPW'(DEPTH)) begin
      sp_q <= sp_q + SPW'(1);
    end else if (pop_i && sp_q != '0) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  // Entries are only visible through sp_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_i && sp_q != SPW'(DEPTH)) mem_q[sp_q] <= data_i;
  end
endmodule

// File: rtl/irq_sequencer.sv
// Interrupt scheduler: latches request edges, waits for a pipeline safe point,
// flushes and redirects to the handler vector; eret unwinds one nesting level.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int              NSRC       = irq_sequencer_pkg::NSRC,
  parameter int              AW         = irq_sequencer_pkg::AW,
  parameter logic [AW-1:0]   VEC_BASE   = irq_sequencer_pkg::VEC_BASE,
  parameter logic [AW-1:0]   VEC_STRIDE = irq_sequencer_pkg::VEC_STRIDE
) (
  input  logic            clk,
  input  logic            in_RST,
  input  logic [NSRC-1:0] irq_in,
  input  logic            ie,
  input  logic [NSRC-1:0] inm,
  input  logic            pipe_en,
  input  logic            branch_ex,
  input  logic [AW-1:0]   resume_pc,
  input  logic            eret_wb,
  output logic            flush_fd,
  output logic            flush_de,
  output logic            flush_em,
  output logic            force_o,
  output logic [AW-1:0]   faddr,
  output logic [NSRC-1:0] ack,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [AW-1:0]   epc
);
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_e          state_q;
  logic [NSRC-1:0] irq_q, pending_q, in_service_q, ack_q;
  logic [NSRC-1:0] pending_d, in_service_d;
  logic [IW-1:0]   sel_q;
  logic            flush_q, force_q;
  logic [AW-1:0]   faddr_q;

  logic [NSRC-1:0] above, elig;
  logic [IW-1:0]   cand, top_is;
  logic            push, pop, can_ret;
  logic [AW-1:0]   top_pc;

  always_comb begin
    // above[i]: no in-service source at priority i or higher.
    for (int i = 0; i < NSRC; i++) begin
      above[i] = 1'b1;
      for (int j = i; j < NSRC; j++) if (in_service_q[j]) above[i] = 1'b0;
    end
    elig      = pending_q & ~inm & {NSRC{ie}} & above;
    cand      = IW'(prio_enc(32'(elig)));
    top_is    = IW'(prio_enc(32'(in_service_q)));
    can_ret   = eret_wb && (in_service_q != '0);
    push      = (state_q == TAKE);
    pop       = (state_q == RET);
    pending_d = (pending_q & ~ack_q) | (irq_in & ~irq_q);
    in_service_d = in_service_q;
    if (push) in_service_d = in_service_q | (NSRC'(1) << sel_q);
    if (pop)  in_service_d = in_service_q & ~(NSRC'(1) << top_is);
  end

  always_ff @(posedge clk) begin
    if (!in_RST) begin
      state_q      <= IDLE;
      irq_q        <= irq_in;
      pending_q    <= '0;
      in_service_q <= '0;
      sel_q        <= '0;
      ack_q        <= '0;
      flush_q      <= 1'b0;
      force_q      <= 1'b0;
      faddr_q      <= '0;
    end else begin
      irq_q        <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ack_q        <= '0;
      flush_q      <= 1'b0;
      force_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (can_ret) begin
            state_q <= RET;
            flush_q <= 1'b1;
            force_q <= 1'b1;
            faddr_q <= top_pc;
          end else if (elig != '0) begin
            state_q <= WAIT;
            sel_q   <= cand;
          end
        end
        WAIT: begin
          if (can_ret) begin
            state_q <= RET;
            flush_q <= 1'b1;
            force_q <= 1'b1;
            faddr_q <= top_pc;
          end else if (elig == '0) begin
            state_q <= IDLE;
          end else if (pipe_en && !branch_ex) begin
            state_q <= TAKE;
            sel_q   <= cand;
            flush_q <= 1'b1;
            force_q <= 1'b1;
            faddr_q <= VEC_BASE + AW'(cand) * VEC_STRIDE;
            ack_q   <= NSRC'(1) << cand;
          end else begin
            sel_q   <= cand;
          end
        end
        TAKE:    state_q <= IDLE;
        RET:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  irq_epc_stack #(.DEPTH(NSRC), .DW(AW)) u_stack (
    .clk    (clk),
    .in_RST (in_RST),
    .push_i (push),
    .pop_i  (pop),
    .data_i (resume_pc),
    .top_o  (top_pc)
  );

  assign flush_fd   = flush_q;
  assign flush_de   = flush_q;
  assign flush_em   = flush_q;
  assign force_o    = force_q;
  assign faddr      = faddr_q;
  assign ack        = ack_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign epc        = top_pc;
endmodule
